fme_best_cand: RTL
==================

FME_BEST_CAND -- requirements
Module: fme_best_cand

Interface
REQ-001 SHALL have parameter LINES, default 8, number of pixel lines accumulated per block (range 2..64).
REQ-002 SHALL have parameter ACC_W, default 16, accumulator and best_sad width (range 12..24).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  per-line SAD beat valid.
REQ-006 SHALL have port in_start  input  1  qualifies the beat as first line of a block.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-008 SHALL have ports sad_UH, sad_UQ, sad_M, sad_LQ, sad_LH  input  60 each  five 12-bit unsigned lane SADs; lane k = bits [12k+11:12k], k=0..4.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-011 SHALL have port best_idx  output  5  winning candidate, row*5+lane; rows UH=0, UQ=1, M=2, LQ=3, LH=4.
REQ-012 SHALL have port best_sad  output  ACC_W  accumulated SAD of winner.

Function
REQ-013 SHALL hold 25 accumulators of ACC_W bits, one per candidate, plus a line counter.
REQ-014 SHALL implement states IDLE, ACCUM, SEARCH, DONE; in_ready = 1 in IDLE and ACCUM only.
REQ-015 IDLE: accepted beat with in_start loads accumulators with zero-extended lane SADs, counter=1, goes to ACCUM; accepted beat without in_start is discarded.
REQ-016 ACCUM: accepted beat without in_start adds lane SADs and increments counter; accepted beat with in_start restarts (load, counter=1).
REQ-017 When the accepted beat brings the counter to LINES, SHALL go to SEARCH on that edge (E0).
REQ-018 SEARCH SHALL examine one candidate per cycle, idx 0 on E1 (initialise), idx 1..24 on E2..E25 (compare); move to DONE at E25 with out_valid=1.
REQ-019 Compare SHALL be strictly-less-than; ties keep the lower index.
REQ-020 DONE: best_idx, best_sad stable while out_valid=1 and out_ready=0; on out_valid & out_ready go to IDLE, out_valid=0 next cycle.
REQ-021 in_valid during SEARCH or DONE SHALL NOT be accepted and SHALL NOT alter state.
REQ-022 LINES=1 not supported; counter width ceil(log2(LINES+1)).

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, counter=0, accumulators=0, out_valid=0, best_idx=0, best_sad=0; in_ready=1 after release.
REQ-024 Reset mid-ACCUM/SEARCH/DONE SHALL discard the partial block; no result emitted.

Configuration
REQ-025 Macro FME_ACC_SAT_EN defined: every accumulator add SHALL saturate at 2^ACC_W-1.
REQ-026 Macro FME_ACC_SAT_EN undefined: accumulator adds SHALL wrap modulo 2^ACC_W; no other behaviour differs.

Verification (LINES=4 unless stated)
REQ-027 All lanes 10 except sad_UQ lane 2 = 3, 4 beats (first with in_start) -> out_valid 25 cycles after final accept, best_idx=7, best_sad=12.
REQ-028 All lanes 5, 4 beats -> best_idx=0, best_sad=20 (tie rule).
REQ-029 Hold out_ready=0 10 cycles in DONE while driving in_valid=1, in_start=1 -> in_ready=0, outputs unchanged; out_ready=1 -> out_valid=0 next cycle, then start beat accepted.
REQ-030 2 beats of lanes 100, then in_start beat + 3 beats all lanes 1 except LH lane 4 = 0 -> best_idx=24, best_sad=0.
REQ-031 ACC_W=12, 4 beats: candidate 0 = 0x400, others 0x3FF -> FME_ACC_SAT_EN: best_idx=1, best_sad=4092; undefined: best_idx=0, best_sad=0.
REQ-032 rst_n low during SEARCH cycle 10 -> out_valid stays 0, in_ready=1 after release, next block result correct.

Source files
------------

// File: rtl/fme_best_cand.sv
// Accumulates per-line SADs for 25 fractional-ME candidates, then scans serially for the minimum.
// Latency: result 25 cycles after the final line is accepted; in_ready low during search/result hold.
// Optional FME_ACC_SAT_EN: accumulator adds saturate instead of wrapping.
module fme_best_cand #(
    parameter int LINES = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_start,
    output logic             in_ready,
    input  logic [59:0]      sad_UH,
    input  logic [59:0]      sad_UQ,
    input  logic [59:0]      sad_M,
    input  logic [59:0]      sad_LQ,
    input  logic [59:0]      sad_LH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       best_idx,
    output logic [ACC_W-1:0] best_sad
);
    localparam int CNT_W = $clog2(LINES + 1);
    localparam int NCAND = 25;

    typedef enum logic [1:0] {IDLE, ACCUM, SEARCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       srch_q, srch_d;
    logic [ACC_W-1:0] acc_q [NCAND];
    logic [ACC_W-1:0] acc_d [NCAND];
    logic [4:0]       best_idx_q, best_idx_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;

    logic [59:0]      row_sad [5];
    logic [11:0]      lane_sad [NCAND];
    logic             accept;
    logic             do_load;
    logic             do_add;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [11:0]      b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W+1)'(b);
`ifdef FME_ACC_SAT_EN
        if (sum[ACC_W]) begin
            return '1;
        end
`endif
        return sum[ACC_W-1:0];
    endfunction

    assign row_sad[0] = sad_UH;
    assign row_sad[1] = sad_UQ;
    assign row_sad[2] = sad_M;
    assign row_sad[3] = sad_LQ;
    assign row_sad[4] = sad_LH;

    // Candidate index is row*5 + lane.
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int l = 0; l < 5; l++) begin
                lane_sad[r*5+l] = row_sad[r][12*l +: 12];
            end
        end
    end

    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        srch_d     = srch_q;
        best_idx_d = best_idx_q;
        best_sad_d = best_sad_q;
        do_load    = 1'b0;
        do_add     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && in_start) begin
                    do_load = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (in_start) begin
                        do_load = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        do_add = 1'b1;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == CNT_W'(LINES)) begin
                            state_d = SEARCH;
                            srch_d  = 5'd0;
                        end
                    end
                end
            end
            SEARCH: begin
                // Candidate 0 seeds the minimum; strict compare keeps the lower index on ties.
                if (srch_q == 5'd0) begin
                    best_idx_d = 5'd0;
                    best_sad_d = acc_q[0];
                end else if (acc_q[srch_q] < best_sad_q) begin
                    best_idx_d = srch_q;
                    best_sad_d = acc_q[srch_q];
                end
                srch_d = srch_q + 5'd1;
                if (srch_q == 5'd24) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NCAND; i++) begin
            if (do_load) begin
                acc_d[i] = ACC_W'(lane_sad[i]);
            end else if (do_add) begin
                acc_d[i] = acc_add(acc_q[i], lane_sad[i]);
            end else begin
                acc_d[i] = acc_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            srch_q     <= '0;
            best_idx_q <= '0;
            best_sad_q <= '0;
            for (int i = 0; i < NCAND; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            srch_q     <= srch_d;
            best_idx_q <= best_idx_d;
            best_sad_q <= best_sad_d;
            for (int i = 0; i < NCAND; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign best_idx  = best_idx_q;
    assign best_sad  = best_sad_q;

endmodule
